// File: rtl/ifetch_ctrl32.sv
// ifetch_ctrl32: instruction-fetch and PC-update controller for the single-cycle MIPS32 core.
// Optional macro IFETCH_MISALIGN_TRAP_EN: misaligned jr targets trap to TRAP_PC and set misalign_err.
module ifetch_ctrl32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0180,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] PC_plus_4,
  input  logic        retire,
  input  logic [31:0] Add_Result,
  input  logic        Zero,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  output logic        fetch_timeout,
  output logic        misalign_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          req_nx, valid_nx, timeout_nx, misalign_nx;
  logic [31:0]   pc_nx, pc_plus_4_nx, instr_nx;

  logic          taken;
  logic          trap;
  logic [31:0]   jump_target, branch_target, jr_target, next_pc;
  logic          unused_bits;

  assign taken         = (Branch & Zero) | (nBranch & ~Zero);
  assign jump_target   = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
  assign branch_target = {Add_Result[29:0], 2'b00};

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign jr_target   = Read_data_1;
  assign trap        = Jrn & (Read_data_1[1:0] != 2'b00);
  assign unused_bits = ^Add_Result[31:30];
`else
  assign jr_target   = {Read_data_1[31:2], 2'b00};
  assign trap        = 1'b0;
  assign unused_bits = ^{Add_Result[31:30], Read_data_1[1:0], TRAP_PC};
`endif

  // Next-PC priority: trap, jr, j/jal, taken branch, sequential.
  always_comb begin
    next_pc = imem_addr + 32'd4;
    if (trap)               next_pc = TRAP_PC;
    else if (Jrn)           next_pc = jr_target;
    else if (Jmp || Jal)    next_pc = jump_target;
    else if (taken)         next_pc = branch_target;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    req_nx       = imem_req;
    valid_nx     = instr_valid;
    timeout_nx   = fetch_timeout;
    misalign_nx  = misalign_err;
    pc_nx        = imem_addr;
    pc_plus_4_nx = PC_plus_4;
    instr_nx     = Instruction;
    case (state)
      ST_BOOT: begin
        state_nx    = ST_FETCH;
        req_nx      = 1'b1;
        wait_cnt_nx = '0;
      end
      ST_FETCH: begin
        if (!imem_req) begin
          // One-cycle gap after a timeout; re-issue the same address.
          req_nx = 1'b1;
        end else if (imem_ready) begin
          instr_nx    = imem_rdata;
          valid_nx    = 1'b1;
          req_nx      = 1'b0;
          wait_cnt_nx = '0;
          state_nx    = ST_EXEC;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timeout_nx  = 1'b1;
          wait_cnt_nx = '0;
          req_nx      = 1'b0;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      ST_EXEC: begin
        if (retire) begin
          pc_nx        = next_pc;
          pc_plus_4_nx = next_pc + 32'd4;
          valid_nx     = 1'b0;
          req_nx       = 1'b1;
          state_nx     = ST_FETCH;
          if (trap) misalign_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_BOOT;
        req_nx   = 1'b0;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_BOOT;
      wait_cnt      <= '0;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      Instruction   <= 32'h0;
      instr_valid   <= 1'b0;
      PC_plus_4     <= RESET_PC + 32'd4;
      fetch_timeout <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= wait_cnt_nx;
      imem_req      <= req_nx;
      imem_addr     <= pc_nx;
      Instruction   <= instr_nx;
      instr_valid   <= valid_nx;
      PC_plus_4     <= pc_plus_4_nx;
      fetch_timeout <= timeout_nx;
      misalign_err  <= misalign_nx;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl32.sv
// Bench for ifetch_ctrl32: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural fetch/PC model. Honours IFETCH_MISALIGN_TRAP_EN.
module tb_ifetch_ctrl32;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0180;
  localparam int          TIMEOUT  = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC_plus_4;
  logic        retire = 1'b0;
  logic [31:0] Add_Result = 32'h0;
  logic        Zero = 1'b0;
  logic [31:0] Read_data_1 = 32'h0;
  logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jrn = 1'b0;
  logic        fetch_timeout;
  logic        misalign_err;

  ifetch_ctrl32 #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .instr_valid(instr_valid), .PC_plus_4(PC_plus_4),
    .retire(retire), .Add_Result(Add_Result), .Zero(Zero), .Read_data_1(Read_data_1),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn),
    .fetch_timeout(fetch_timeout), .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the fetch unit is doing and what it must show.
  int          m_phase;   // 0 boot, 1 fetching, 2 holding instruction
  int          m_wait;
  logic        m_req, m_valid, m_to, m_mis;
  logic [31:0] m_addr, m_instr, m_pp4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_misaligned_jr();
`ifdef IFETCH_MISALIGN_TRAP_EN
    return Jrn && (Read_data_1 % 32'd4 != 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_next_pc();
    if (Jrn) begin
      if (model_misaligned_jr()) return TRAP_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      return Read_data_1;
`else
      return Read_data_1 - (Read_data_1 % 32'd4);
`endif
    end
    if (Jmp || Jal) return (m_pp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
    if ((Branch && Zero) || (nBranch && !Zero)) return Add_Result * 32'd4;
    return m_addr + 32'd4;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wait = 0;
    m_req = 1'b0; m_valid = 1'b0; m_to = 1'b0; m_mis = 1'b0;
    m_addr = RESET_PC; m_instr = 32'h0; m_pp4 = RESET_PC + 32'd4;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      m_phase = 1; m_req = 1'b1; m_wait = 0;
    end else if (m_phase == 1) begin
      if (!m_req) m_req = 1'b1;
      else if (imem_ready) begin
        m_instr = imem_rdata; m_valid = 1'b1; m_req = 1'b0; m_phase = 2; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_to = 1'b1; m_wait = 0; m_req = 1'b0;
        end
      end
    end else if (retire) begin
      if (model_misaligned_jr()) m_mis = 1'b1;
      m_addr = model_next_pc();
      m_pp4 = m_addr + 32'd4;
      m_valid = 1'b0; m_req = 1'b1; m_phase = 1;
    end
  endtask

  task automatic compare_all();
    check("imem_req", 32'(imem_req), 32'(m_req));
    check("imem_addr", imem_addr, m_addr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("Instruction", Instruction, m_instr);
    check("PC_plus_4", PC_plus_4, m_pp4);
    check("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  // One clock: model follows the edge, outputs compared 1ns later, return at the falling edge.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic fetch_word(input logic [31:0] word);
    int n = 0;
    imem_ready = 1'b0;
    while (!m_req && n < 40) begin cyc(); n++; end
    if (!m_req) begin
      checks++; errors++;
      $display("FAIL fetch_wait: no request seen within 40 cycles at %0t", $time);
    end
    imem_ready = 1'b1; imem_rdata = word;
    cyc();
    imem_ready = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic retire_ctl(input logic br, input logic nbr, input logic jmp, input logic jal,
                            input logic jrn, input logic zero, input logic [31:0] add,
                            input logic [31:0] rd1);
    Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jrn = jrn; Zero = zero;
    Add_Result = add; Read_data_1 = rd1; retire = 1'b1;
    cyc();
    retire = 1'b0; Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jrn = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] pc);
    fetch_word(32'h0);
    retire_ctl(0, 0, 0, 0, 1, 0, 32'h0, pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_instr, held_pp4, exp_jr;
    int ready_pct;

    model_reset();
    repeat (3) @(negedge clock);
    compare_all();
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pp4", PC_plus_4, 32'h4);
    check("rst_instr", Instruction, 32'h0);

    // Boot cycle, then request at RESET_PC; zero-wait fetch and immediate retire.
    reset_n = 1'b1;
    cyc();
    check("boot_req", 32'(imem_req), 32'h1);
    check("boot_addr", imem_addr, 32'h0);
    fetch_word(32'h2008_0005);
    check("first_valid", 32'(instr_valid), 32'h1);
    check("first_instr", Instruction, 32'h2008_0005);
    retire_ctl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("seq_addr", imem_addr, 32'h4);
    check("seq_req", 32'(imem_req), 32'h1);
    check("seq_valid", 32'(instr_valid), 32'h0);

    // Branches from PC 0x10.
    goto_pc(32'h10);
    check("goto_10", imem_addr, 32'h10);
    fetch_word(32'h1000_0002);
    retire_ctl(1, 0, 0, 0, 0, 1, 32'h8, 32'h0);
    check("beq_taken", imem_addr, 32'h20);
    goto_pc(32'h10);
    fetch_word(32'h1000_0002);
    retire_ctl(1, 0, 0, 0, 0, 0, 32'h8, 32'h0);
    check("beq_not_taken", imem_addr, 32'h14);
    goto_pc(32'h10);
    fetch_word(32'h1400_0002);
    retire_ctl(0, 1, 0, 0, 0, 0, 32'h8, 32'h0);
    check("bne_taken", imem_addr, 32'h20);

    // jal keeps the upper nibble of PC+4.
    goto_pc(32'h3000_0004);
    fetch_word(32'h0800_0040);
    check("jal_pp4", PC_plus_4, 32'h3000_0008);
    retire_ctl(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    check("jal_target", imem_addr, 32'h3000_0100);

    // PC wraps at the top of the address space.
    goto_pc(32'hFFFF_FFFC);
    fetch_word(32'h0);
    check("wrap_pp4", PC_plus_4, 32'h0);
    retire_ctl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Misaligned jr.
    fetch_word(32'h0040_0008);
    retire_ctl(0, 0, 0, 0, 1, 0, 32'h0, 32'h42);
`ifdef IFETCH_MISALIGN_TRAP_EN
    exp_jr = 32'h180;
    check("jr_mis_flag", 32'(misalign_err), 32'h1);
`else
    exp_jr = 32'h40;
    check("jr_mis_flag", 32'(misalign_err), 32'h0);
`endif
    check("jr_target", imem_addr, exp_jr);

    // Ready on the last permitted wait cycle wins over the timeout.
    repeat (TIMEOUT - 1) cyc();
    fetch_word(32'h1111_2222);
    check("late_ready_valid", 32'(instr_valid), 32'h1);
    check("late_ready_noto", 32'(fetch_timeout), 32'h0);
    retire_ctl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("late_ready_next", imem_addr, exp_jr + 32'd4);

    // Full timeout: request drops one cycle, ready in that gap is ignored, same address re-issued.
    repeat (TIMEOUT - 1) cyc();
    check("pre_to_req", 32'(imem_req), 32'h1);
    check("pre_to_flag", 32'(fetch_timeout), 32'h0);
    cyc();
    check("to_req", 32'(imem_req), 32'h0);
    check("to_flag", 32'(fetch_timeout), 32'h1);
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    imem_ready = 1'b0;
    check("reissue_req", 32'(imem_req), 32'h1);
    check("reissue_addr", imem_addr, exp_jr + 32'd4);
    check("gap_ignored", 32'(instr_valid), 32'h0);
    fetch_word(32'hDEAD_BEEF);
    check("after_to_valid", 32'(instr_valid), 32'h1);

    // Stall: retire low for 10 cycles holds everything.
    held_instr = m_instr; held_pp4 = m_pp4;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("stall_instr", Instruction, 32'hDEAD_BEEF);
      check("stall_pp4", PC_plus_4, held_pp4);
      check("stall_req", 32'(imem_req), 32'h0);
    end
    check("stall_model_instr", held_instr, Instruction);
    retire_ctl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset mid-fetch with a response pending.
    cyc();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_addr", imem_addr, RESET_PC);
    check("arst_to", 32'(fetch_timeout), 32'h0);
    @(negedge clock);
    imem_ready = 1'b0;
    reset_n = 1'b1;
    cyc();
    check("restart_req", 32'(imem_req), 32'h1);
    check("restart_addr", imem_addr, RESET_PC);
    check("restart_valid", 32'(instr_valid), 32'h0);

    // Randomized traffic against the model.
    ready_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) begin
        case ($urandom_range(0, 3))
          0: ready_pct = 0;
          1: ready_pct = 10;
          2: ready_pct = 60;
          default: ready_pct = 100;
        endcase
      end
      imem_ready  = ($urandom_range(0, 99) < ready_pct);
      imem_rdata  = $urandom;
      retire      = $urandom_range(0, 1) == 1;
      Zero        = $urandom_range(0, 1) == 1;
      Branch      = $urandom_range(0, 3) == 0;
      nBranch     = $urandom_range(0, 3) == 0;
      Jmp         = $urandom_range(0, 7) == 0;
      Jal         = $urandom_range(0, 7) == 0;
      Jrn         = $urandom_range(0, 7) == 0;
      Add_Result  = $urandom;
      Read_data_1 = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl32.md
# ifetch_ctrl32

Sequential instruction-fetch and PC-update controller for the single-cycle MIPS32 core. It sits at the far end of the execute stage: it consumes the branch target word address, Zero flag and jump controls that execute/control produce, and computes the next PC. It fetches from a variable-latency instruction memory over a req/ready handshake and holds each instruction stable until the core retires it.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- TRAP_PC, 32'h0000_0180, PC loaded on misaligned jr target (only with macro)
- TIMEOUT, 16, max wait cycles for imem_ready before re-issue (>=2)
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, high in FETCH
- imem_addr  out  32  byte address of fetch (= PC)
- imem_ready  in  1  rdata valid this cycle; honoured only while imem_req=1
- imem_rdata  in  32  instruction word
- Instruction  out  32  latched instruction, stable while instr_valid=1
- instr_valid  out  1  Instruction is valid for decode/execute
- PC_plus_4  out  32  PC+4 of the held instruction (feeds execute and jal link)
- retire  in  1  core has finished the held instruction this cycle
- Add_Result  in  32  branch target word address from execute
- Zero  in  1  ALU zero flag from execute
- Read_data_1  in  32  rs value, jr target
- Branch, nBranch, Jmp, Jal, Jrn  in  1 each  controller decodes for held instruction
- fetch_timeout  out  1  sticky; set on any imem timeout
- misalign_err  out  1  sticky; see Configuration

## Operation
- States: BOOT, FETCH, EXEC.
- BOOT: entered on reset; PC=RESET_PC; one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=PC, wait counter increments. On imem_ready: latch imem_rdata into Instruction, go to EXEC. If counter reaches TIMEOUT with no ready: set fetch_timeout, clear counter, drop imem_req for one cycle, re-issue same address.
- EXEC: instr_valid=1, Instruction and PC_plus_4 frozen. retire=0 holds indefinitely (stall). retire=1: PC <= next_pc, go to FETCH.
- next_pc priority: Jrn -> Read_data_1; else Jmp|Jal -> {PC_plus_4[31:28], Instruction[25:0], 2'b00}; else taken branch -> {Add_Result[29:0], 2'b00}; else PC+4.
- taken = (Branch & Zero) | (nBranch & ~Zero).
- All PC arithmetic is 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0.
- imem_ready outside FETCH is ignored; retire outside EXEC is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, Instruction=0, instr_valid=0, PC_plus_4=RESET_PC+4, fetch_timeout=0, misalign_err=0.
- Reset deassert -> BOOT 1 cycle -> imem_req high next cycle.
- imem_ready sampled at edge N -> instr_valid=1 from N (registered, visible after edge N).
- retire sampled at edge M -> instr_valid=0 and imem_req=1 with new imem_addr after edge M; minimum 2 cycles per instruction with zero-wait memory.
- imem_ready and timeout on same edge: ready wins, no flag.
- Reset asserted mid-fetch: imem_req drops asynchronously; outstanding response discarded.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined: Jrn retire with Read_data_1[1:0]!=0 sets misalign_err (sticky until reset) and loads PC=TRAP_PC instead of the target.
- Undefined: jr target low two bits forced to 00; misalign_err tied 0; TRAP_PC unused.

## Test plan
- Reset release, zero-wait memory returning 32'h2008_0005, retire immediately -> imem_addr 0, Instruction 32'h2008_0005, next imem_addr 0x4; two cycles per instruction.
- PC=0x10, Branch=1, Zero=1, Add_Result=0x0000_0008, retire -> next imem_addr 0x20; same with Zero=0 -> 0x14; nBranch=1, Zero=0 -> 0x20.
- PC=0x3000_0004, Instruction=0x0800_0040, Jal=1 -> next imem_addr 0x3000_0100; PC_plus_4 during EXEC = 0x3000_0008.
- Jrn=1, Read_data_1=0x0000_0042: with macro -> imem_addr 0x180, misalign_err=1; without -> 0x40, misalign_err=0.
- imem_ready withheld 16 cycles -> fetch_timeout=1, req low one cycle, re-issue same address; then ready returns and instr_valid=1.
- retire held 0 for 10 cycles -> Instruction/PC_plus_4 unchanged, imem_req=0; reset_n pulsed mid-FETCH -> imem_req=0 immediately, restart at RESET_PC.
